regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter
// Brief    : Round-robin front end letting two requesters share one
//            registered-read register file, one command in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_arbiter #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic              a_req_second_read,
    input  logic [31:0]       a_req_addr_1,
    input  logic [31:0]       a_req_addr_2,
    input  logic [31:0]       a_req_waddr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_resp_valid,
    input  logic              a_resp_ready,
    output logic [DATA_W-1:0] a_resp_data_1,
    output logic [DATA_W-1:0] a_resp_data_2,
    output logic              a_resp_err,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic              b_req_second_read,
    input  logic [31:0]       b_req_addr_1,
    input  logic [31:0]       b_req_addr_2,
    input  logic [31:0]       b_req_waddr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_resp_valid,
    input  logic              b_resp_ready,
    output logic [DATA_W-1:0] b_resp_data_1,
    output logic [DATA_W-1:0] b_resp_data_2,
    output logic              b_resp_err,
    output logic              rf_write_enable,
    output logic              rf_second_read,
    output logic [31:0]       rf_read_address_1,
    output logic [31:0]       rf_read_address_2,
    output logic [31:0]       rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2
);

    localparam logic [1:0]  c_st_idle    = 2'd0;
    localparam logic [1:0]  c_st_issue   = 2'd1;
    localparam logic [1:0]  c_st_capture = 2'd2;
    localparam logic [1:0]  c_st_resp    = 2'd3;
    localparam logic [31:0] c_num_regs   = 32'(NUM_REGS);

    logic [1:0]        r_state;
    logic              r_ptr;      // 0: a has priority, 1: b has priority
    logic              r_owner;    // 0: a, 1: b
    logic              r_cmd_second_read;
    logic              r_cmd_zero_1;
    logic              r_cmd_zero_2;
    logic              r_a_resp_valid;
    logic              r_b_resp_valid;
    logic              r_a_resp_err;
    logic              r_b_resp_err;
    logic [DATA_W-1:0] r_resp_data_1;
    logic [DATA_W-1:0] r_resp_data_2;
    logic              r_rf_we;
    logic              r_rf_second_read;
    logic [31:0]       r_rf_raddr_1;
    logic [31:0]       r_rf_raddr_2;
    logic [31:0]       r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_idle;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic              w_sel_we;
    logic              w_sel_second;
    logic [31:0]       w_sel_addr_1;
    logic [31:0]       w_sel_addr_2;
    logic [31:0]       w_sel_waddr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_err;
    logic              w_resp_hs;

    // Ready is gated by rst so nothing is offered while reset is held.
    assign w_idle    = (r_state == c_st_idle) && !rst;
    assign w_grant_a = a_req_valid && (!b_req_valid || !r_ptr);
    assign w_grant_b = b_req_valid && (!a_req_valid || r_ptr);
    assign w_accept  = w_idle && (a_req_valid || b_req_valid);

    assign w_sel_we     = w_grant_b ? b_req_we          : a_req_we;
    assign w_sel_second = w_grant_b ? b_req_second_read : a_req_second_read;
    assign w_sel_addr_1 = w_grant_b ? b_req_addr_1      : a_req_addr_1;
    assign w_sel_addr_2 = w_grant_b ? b_req_addr_2      : a_req_addr_2;
    assign w_sel_waddr  = w_grant_b ? b_req_waddr       : a_req_waddr;
    assign w_sel_wdata  = w_grant_b ? b_req_wdata       : a_req_wdata;

    // Only addresses the command actually uses can make it illegal.
    assign w_err = (w_sel_addr_1 >= c_num_regs)
                || (w_sel_second && (w_sel_addr_2 >= c_num_regs))
                || (w_sel_we && (w_sel_waddr >= c_num_regs));

    assign w_resp_hs = (r_a_resp_valid && a_resp_ready) || (r_b_resp_valid && b_resp_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= c_st_idle;
            r_ptr             <= 1'b0;
            r_owner           <= 1'b0;
            r_cmd_second_read <= 1'b0;
            r_cmd_zero_1      <= 1'b0;
            r_cmd_zero_2      <= 1'b0;
            r_a_resp_valid    <= 1'b0;
            r_b_resp_valid    <= 1'b0;
            r_a_resp_err      <= 1'b0;
            r_b_resp_err      <= 1'b0;
            r_resp_data_1     <= '0;
            r_resp_data_2     <= '0;
            r_rf_we           <= 1'b0;
            r_rf_second_read  <= 1'b0;
            r_rf_raddr_1      <= '0;
            r_rf_raddr_2      <= '0;
            r_rf_waddr        <= '0;
            r_rf_wdata        <= '0;
        end else begin
            r_rf_we          <= 1'b0;
            r_rf_second_read <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_owner <= w_grant_b;
                        r_ptr   <= !w_grant_b;
                        if (w_err) begin
                            r_resp_data_1  <= '0;
                            r_resp_data_2  <= '0;
                            r_a_resp_valid <= !w_grant_b;
                            r_b_resp_valid <= w_grant_b;
                            r_a_resp_err   <= !w_grant_b;
                            r_b_resp_err   <= w_grant_b;
                            r_state        <= c_st_resp;
                        end else begin
                            // rf strobes are registered here so they are live for exactly the ISSUE cycle.
                            r_cmd_second_read <= w_sel_second;
                            r_cmd_zero_1      <= (w_sel_addr_1 == 32'd0);
                            r_cmd_zero_2      <= (w_sel_addr_2 == 32'd0);
                            r_rf_we           <= w_sel_we && (w_sel_waddr != 32'd0);
                            r_rf_second_read  <= w_sel_second;
                            r_rf_raddr_1      <= w_sel_addr_1;
                            r_rf_raddr_2      <= w_sel_addr_2;
                            r_rf_waddr        <= w_sel_waddr;
                            r_rf_wdata        <= w_sel_wdata;
                            r_state           <= c_st_issue;
                        end
                    end
                end
                c_st_issue: begin
                    r_state <= c_st_capture;
                end
                c_st_capture: begin
                    r_resp_data_1  <= r_cmd_zero_1 ? '0 : rf_read_data_1;
                    r_resp_data_2  <= (r_cmd_second_read && !r_cmd_zero_2) ? rf_read_data_2 : '0;
                    r_a_resp_valid <= !r_owner;
                    r_b_resp_valid <= r_owner;
                    r_a_resp_err   <= 1'b0;
                    r_b_resp_err   <= 1'b0;
                    r_state        <= c_st_resp;
                end
                c_st_resp: begin
                    if (w_resp_hs) begin
                        r_a_resp_valid <= 1'b0;
                        r_b_resp_valid <= 1'b0;
                        r_a_resp_err   <= 1'b0;
                        r_b_resp_err   <= 1'b0;
                        r_state        <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign a_req_ready       = w_idle && w_grant_a;
    assign b_req_ready       = w_idle && w_grant_b;
    assign a_resp_valid      = r_a_resp_valid;
    assign b_resp_valid      = r_b_resp_valid;
    assign a_resp_err        = r_a_resp_err;
    assign b_resp_err        = r_b_resp_err;
    assign a_resp_data_1     = r_resp_data_1;
    assign a_resp_data_2     = r_resp_data_2;
    assign b_resp_data_1     = r_resp_data_1;
    assign b_resp_data_2     = r_resp_data_2;
    assign rf_write_enable   = r_rf_we;
    assign rf_second_read    = r_rf_second_read;
    assign rf_read_address_1 = r_rf_raddr_1;
    assign rf_read_address_2 = r_rf_raddr_2;
    assign rf_write_address  = r_rf_waddr;
    assign rf_write_data     = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_arbiter
// Brief    : Directed table, corner sequences and a randomized two-requester
//            run scored against a shadow register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_arbiter;
    localparam int DW = 32;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0, a_req_second_read = 1'b0;
    logic [31:0]   a_req_addr_1 = '0, a_req_addr_2 = '0, a_req_waddr = '0;
    logic [DW-1:0] a_req_wdata = '0;
    logic          a_resp_valid, a_resp_ready = 1'b1, a_resp_err;
    logic [DW-1:0] a_resp_data_1, a_resp_data_2;
    logic          b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0, b_req_second_read = 1'b0;
    logic [31:0]   b_req_addr_1 = '0, b_req_addr_2 = '0, b_req_waddr = '0;
    logic [DW-1:0] b_req_wdata = '0;
    logic          b_resp_valid, b_resp_ready = 1'b1, b_resp_err;
    logic [DW-1:0] b_resp_data_1, b_resp_data_2;
    logic          rf_write_enable, rf_second_read;
    logic [31:0]   rf_read_address_1, rf_read_address_2, rf_write_address;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_read_data_1 = '0, rf_read_data_2 = '0;

    regfile_arbiter #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_second_read(a_req_second_read), .a_req_addr_1(a_req_addr_1),
        .a_req_addr_2(a_req_addr_2), .a_req_waddr(a_req_waddr), .a_req_wdata(a_req_wdata),
        .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
        .a_resp_data_1(a_resp_data_1), .a_resp_data_2(a_resp_data_2), .a_resp_err(a_resp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_second_read(b_req_second_read), .b_req_addr_1(b_req_addr_1),
        .b_req_addr_2(b_req_addr_2), .b_req_waddr(b_req_waddr), .b_req_wdata(b_req_wdata),
        .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
        .b_resp_data_1(b_resp_data_1), .b_resp_data_2(b_resp_data_2), .b_resp_err(b_resp_err),
        .rf_write_enable(rf_write_enable), .rf_second_read(rf_second_read),
        .rf_read_address_1(rf_read_address_1), .rf_read_address_2(rf_read_address_2),
        .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2)
    );

    // Registered-read register file attached to the DUT.
    logic [DW-1:0] rf_mem [NR];
    initial for (int i = 0; i < NR; i++) rf_mem[i] = DW'(i);
    always @(posedge clk) begin
        if (rf_write_enable && rf_write_address < NR) rf_mem[rf_write_address[4:0]] <= rf_write_data;
        rf_read_data_1 <= (rf_read_address_1 < NR) ? rf_mem[rf_read_address_1[4:0]] : '0;
        rf_read_data_2 <= (rf_read_address_2 < NR) ? rf_mem[rf_read_address_2[4:0]] : '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int rf_we_cnt = 0;
    always @(negedge clk) if (rf_write_enable) rf_we_cnt++;

    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: one command in flight ----------------
    logic [DW-1:0] ref_mem [NR];
    initial for (int i = 0; i < NR; i++) ref_mem[i] = DW'(i);
    bit            m_busy = 0, m_ptr = 0, m_owner = 0, m_err = 0, m_wr = 0;
    int            m_acc = 0, m_lat = 0;
    logic [DW-1:0] m_d1, m_d2, m_wdata;
    logic [31:0]   m_waddr;
    bit            mw_any, mw_b, mw_on;
    logic          mv_we, mv_sec;
    logic [31:0]   mv_a1, mv_a2, mv_wa;
    logic [DW-1:0] mv_wd;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            mw_any = a_req_valid || b_req_valid;
            mw_b   = b_req_valid && (!a_req_valid || m_ptr);
            chk("a_req_ready grant", a_req_ready, mw_any && !mw_b);
            chk("b_req_ready grant", b_req_ready, mw_b);
            chk("resp_valid while idle", {a_resp_valid, b_resp_valid}, 0);
            chk("rf_write_enable while idle", rf_write_enable, 0);
            if (mw_any) begin
                m_owner = mw_b;
                m_ptr   = !mw_b;
                m_busy  = 1;
                m_acc   = cyc;
                mv_we  = mw_b ? b_req_we : a_req_we;
                mv_sec = mw_b ? b_req_second_read : a_req_second_read;
                mv_a1  = mw_b ? b_req_addr_1 : a_req_addr_1;
                mv_a2  = mw_b ? b_req_addr_2 : a_req_addr_2;
                mv_wa  = mw_b ? b_req_waddr : a_req_waddr;
                mv_wd  = mw_b ? b_req_wdata : a_req_wdata;
                m_err  = (mv_a1 >= NR) || (mv_sec && mv_a2 >= NR) || (mv_we && mv_wa >= NR);
                m_lat  = m_err ? 1 : 3;
                m_d1   = (m_err || mv_a1 == 0) ? '0 : ref_mem[mv_a1[4:0]];
                m_d2   = (m_err || !mv_sec || mv_a2 == 0) ? '0 : ref_mem[mv_a2[4:0]];
                m_wr   = !m_err && mv_we && (mv_wa != 0);
                m_waddr = mv_wa;
                m_wdata = mv_wd;
            end
        end else begin
            mw_on = (cyc >= m_acc + m_lat);
            chk("req_ready while busy", {a_req_ready, b_req_ready}, 0);
            chk("owner resp_valid", m_owner ? b_resp_valid : a_resp_valid, mw_on);
            chk("non-owner resp_valid", m_owner ? a_resp_valid : b_resp_valid, 0);
            chk("rf_write_enable timing", rf_write_enable, m_wr && (cyc == m_acc + 1));
            if (m_wr && cyc == m_acc + 1) begin
                chk("rf_write_address", rf_write_address, m_waddr);
                chk("rf_write_data", rf_write_data, m_wdata);
            end
            if (mw_on) begin
                chk("resp_data_1", m_owner ? b_resp_data_1 : a_resp_data_1, m_d1);
                chk("resp_data_2", m_owner ? b_resp_data_2 : a_resp_data_2, m_d2);
                chk("resp_err", m_owner ? b_resp_err : a_resp_err, m_err);
                if (m_owner ? b_resp_ready : a_resp_ready) begin
                    if (m_wr) ref_mem[m_waddr[4:0]] = m_wdata;
                    m_busy = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input bit who, input logic v, input logic we, input logic sec,
                           input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] wa,
                           input logic [DW-1:0] wd);
        if (who) begin
            b_req_valid = v; b_req_we = we; b_req_second_read = sec;
            b_req_addr_1 = a1; b_req_addr_2 = a2; b_req_waddr = wa; b_req_wdata = wd;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_second_read = sec;
            a_req_addr_1 = a1; a_req_addr_2 = a2; a_req_waddr = wa; a_req_wdata = wd;
        end
    endtask

    function automatic bit fire(input bit who);
        return who ? (b_req_valid && b_req_ready) : (a_req_valid && a_req_ready);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'(32 + $urandom_range(0, 100));
        if (r == 1) return 32'd0;
        return 32'($urandom_range(0, NR - 1));
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one command from a lone requester; entered and left at posedge+1.
    task automatic run_cmd(input bit who, input logic we, input logic sec,
                           input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] wa,
                           input logic [DW-1:0] wd,
                           output logic [DW-1:0] d1, output logic [DW-1:0] d2, output logic err,
                           output int lat, output int wait_n, output int wr_n);
        int k, acc, w0;
        w0 = rf_we_cnt;
        set_req(who, 1, we, sec, a1, a2, wa, wd);
        k = 0;
        do begin @(negedge clk); k++; end while (!fire(who) && k < 50);
        wait_n = k;
        acc = cyc;
        @(posedge clk); #1;
        set_req(who, 0, 0, 0, 0, 0, 0, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!(who ? b_resp_valid : a_resp_valid) && k < 50);
        lat  = cyc - acc;
        d1   = who ? b_resp_data_1 : a_resp_data_1;
        d2   = who ? b_resp_data_2 : a_resp_data_2;
        err  = who ? b_resp_err : a_resp_err;
        wr_n = rf_we_cnt - w0;
        @(posedge clk); #1;
    endtask

    // Keep a requester busy with n back-to-back (or randomly gapped) commands.
    task automatic drive_cmds(input bit who, input int n, input bit rnd);
        int k;
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                set_req(who, 0, 0, 0, 0, 0, 0, 0);
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            if (rnd)
                set_req(who, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        rnd_addr(), rnd_addr(), rnd_addr(), $urandom);
            else
                set_req(who, 1, 0, 1, 32'(i + 1), 32'(i + 2), 0, 0);
            k = 0;
            do begin @(negedge clk); k++; end while (!fire(who) && k < 200);
            if (k >= 200) begin
                chk(who ? "b accept timeout" : "a accept timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        set_req(who, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          who;
        bit          we;
        bit          sec;
        logic [31:0] a1, a2, wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] e1, e2;
        bit          eerr;
        int          elat;
        int          ewr;
    } vec_t;

    vec_t          tbl [12];
    logic [DW-1:0] g_d1, g_d2;
    logic          g_err;
    int            g_lat, g_wait, g_wr, w0, k;
    int            order [8];
    bit            done = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            who we sec a1      a2      wa      wd             e1            e2            err lat wr
        tbl[0]  = '{0, 1, 0, 32'd5,  32'd0,  32'd5,  32'hDEADBEEF, 32'd5,        32'd0,        0,  3,  1};
        tbl[1]  = '{0, 0, 0, 32'd5,  32'd0,  32'd0,  32'd0,        32'hDEADBEEF, 32'd0,        0,  3,  0};
        tbl[2]  = '{1, 0, 1, 32'd0,  32'd1,  32'd0,  32'd0,        32'd0,        32'd1,        0,  3,  0};
        tbl[3]  = '{1, 1, 0, 32'd2,  32'd0,  32'd0,  32'h55,       32'd2,        32'd0,        0,  3,  0};
        tbl[4]  = '{0, 0, 0, 32'd32, 32'd0,  32'd0,  32'd0,        32'd0,        32'd0,        1,  1,  0};
        tbl[5]  = '{1, 0, 0, 32'd4,  32'd40, 32'd0,  32'd0,        32'd4,        32'd0,        0,  3,  0};
        tbl[6]  = '{1, 0, 1, 32'd4,  32'd40, 32'd0,  32'd0,        32'd0,        32'd0,        1,  1,  0};
        tbl[7]  = '{0, 1, 1, 32'd31, 32'd5,  32'd31, 32'h12345678, 32'd31,       32'hDEADBEEF, 0,  3,  1};
        tbl[8]  = '{0, 1, 0, 32'd1,  32'd0,  32'd32, 32'd1,        32'd0,        32'd0,        1,  1,  0};
        tbl[9]  = '{1, 0, 0, 32'd31, 32'd0,  32'd0,  32'd0,        32'h12345678, 32'd0,        0,  3,  0};
        tbl[10] = '{0, 0, 0, 32'd0,  32'd0,  32'd99, 32'd0,        32'd0,        32'd0,        0,  3,  0};
        tbl[11] = '{1, 0, 0, 32'd6,  32'd7,  32'd0,  32'd0,        32'd6,        32'd0,        0,  3,  0};

        // Reset state, with a request pending to prove ready is held low.
        a_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset a_req_ready", a_req_ready, 0);
        chk("reset resp_valid", {a_resp_valid, b_resp_valid}, 0);
        chk("reset resp_err", {a_resp_err, b_resp_err}, 0);
        chk("reset rf strobes", {rf_write_enable, rf_second_read}, 0);
        chk("reset rf addresses", {rf_read_address_1, rf_write_address}, 0);
        chk("reset resp data", {a_resp_data_1, b_resp_data_2}, 0);
        a_req_valid = 1'b0;
        rst = 1'b0;

        // Directed table; first row is accepted on the first edge after reset.
        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].who, tbl[i].we, tbl[i].sec, tbl[i].a1, tbl[i].a2, tbl[i].wa, tbl[i].wd,
                    g_d1, g_d2, g_err, g_lat, g_wait, g_wr);
            chk($sformatf("row%0d accept wait", i), g_wait, 1);
            chk($sformatf("row%0d data_1", i), g_d1, tbl[i].e1);
            chk($sformatf("row%0d data_2", i), g_d2, tbl[i].e2);
            chk($sformatf("row%0d err", i), g_err, tbl[i].eerr);
            chk($sformatf("row%0d latency", i), g_lat, tbl[i].elat);
            chk($sformatf("row%0d rf writes", i), g_wr, tbl[i].ewr);
        end

        // Both requesters saturating: grants alternate starting with a.
        do_reset();
        fork
            drive_cmds(0, 4, 0);
            drive_cmds(1, 4, 0);
            begin
                for (int i = 0; i < 8; i++) begin
                    int kk;
                    kk = 0;
                    do begin @(negedge clk); kk++; end while (!(fire(0) || fire(1)) && kk < 100);
                    order[i] = (kk >= 100) ? -1 : int'(fire(1));
                end
            end
        join
        for (int i = 0; i < 8; i++) chk($sformatf("grant order %0d", i), order[i], i % 2);
        repeat (6) @(posedge clk);
        #1;

        // Illegal address: fast error, held under backpressure, b waits.
        do_reset();
        a_resp_ready = 1'b0;
        set_req(0, 1, 0, 0, 32'd32, 0, 0, 0);
        set_req(1, 1, 0, 0, 32'd3, 0, 0, 0);
        @(negedge clk);
        chk("err cmd a ready", {a_req_ready, b_req_ready}, 2'b10);
        w0 = rf_we_cnt;
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("err resp at T+1", {a_resp_valid, a_resp_err}, 2'b11);
        chk("err resp data", {a_resp_data_1, a_resp_data_2}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("err hold %0d", i), {a_resp_valid, a_resp_err, b_req_ready}, 3'b110);
        end
        @(posedge clk); #1;
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b accepted after err handshake", b_req_ready, 1);
        chk("err no rf strobe", rf_we_cnt - w0, 0);
        @(posedge clk); #1;
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset during ISSUE of a write to reg 7.
        do_reset();
        set_req(0, 1, 1, 0, 32'd7, 0, 32'd7, 32'h0BADF00D);
        @(negedge clk);
        chk("rst-seq accept", a_req_ready, 1);
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst-seq issue strobe", rf_write_enable, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst-seq we cleared", rf_write_enable, 0);
        chk("rst-seq rf outputs cleared", {rf_write_address, rf_write_data, rf_read_address_1}, 0);
        chk("rst-seq no response", a_resp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        k = 0;
        repeat (4) begin @(negedge clk); if (a_resp_valid) k++; end
        chk("rst-seq abandoned response", k, 0);
        @(posedge clk); #1;
        run_cmd(0, 0, 0, 32'd7, 0, 0, 0, g_d1, g_d2, g_err, g_lat, g_wait, g_wr);
        chk("reg7 unchanged", g_d1, 32'd7);
        chk("reg7 read err", g_err, 0);

        // Randomized traffic scored by the reference model.
        fork
            begin
                fork
                    drive_cmds(0, 80, 1);
                    drive_cmds(1, 80, 1);
                join
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    a_resp_ready = ($urandom_range(0, 3) != 0);
                    b_resp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        a_resp_ready = 1'b1;
        b_resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("random drain", m_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
